guffin_vend_ctrl: RTL and testbench
===================================

GUFFIN_VEND_CTRL -- requirements
Module: guffin_vend_ctrl

Interface
REQ-001 The block SHALL have parameter PRICE_Q, default 3, guffin price in quarters (legal 1..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1000, idle cycles before auto-refund (used only under GUFFIN_TIMEOUT_EN).
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port coinValid  input  1  one-cycle coin-inserted strobe.
REQ-006 The block SHALL have port coinType  input  2  coin code: 01 quarter, 10 half dollar, 11 dollar, 00 invalid.
REQ-007 The block SHALL have port cancel  input  1  customer refund request, level sampled.
REQ-008 The block SHALL have port changeAck  input  1  dispenser has ejected the requested coin.
REQ-009 The block SHALL have port guffin  output  1  one-cycle vend pulse.
REQ-010 The block SHALL have port changeReq  output  1  change coin requested, held until changeAck.
REQ-011 The block SHALL have port changeCoin  output  2  coin requested: 01 quarter, 10 half dollar.
REQ-012 The block SHALL have port coinReject  output  1  one-cycle pulse, last coin returned uncredited.
REQ-013 The block SHALL have port credit  output  4  current credit in quarters.
REQ-014 The block SHALL have port busy  output  1  high in VEND, CHANGE.

Function
REQ-015 The FSM SHALL have states IDLE (credit 0), COLLECT, VEND, CHANGE.
REQ-016 In IDLE/COLLECT, a valid coin on edge N SHALL add 1/2/4 quarters to credit, visible after edge N.
REQ-017 If the updated credit >= PRICE_Q, the FSM SHALL enter VEND; otherwise COLLECT.
REQ-018 VEND SHALL last exactly one cycle with guffin=1 and credit reduced by PRICE_Q on exit; next state CHANGE if remainder > 0, else IDLE.
REQ-019 CHANGE SHALL drive changeReq=1 with changeCoin=10 when credit >= 2, else 01; changeCoin SHALL be stable while changeReq=1 and changeAck=0.
REQ-020 On changeAck in CHANGE, credit SHALL drop by the coin value; changeReq SHALL stay high with the recomputed coin if credit remains, else FSM returns to IDLE and changeReq drops next cycle.
REQ-021 changeAck outside CHANGE SHALL be ignored.
REQ-022 cancel in COLLECT SHALL move to CHANGE, refunding full credit; cancel in IDLE, VEND, CHANGE SHALL be ignored.
REQ-023 Simultaneous coinValid and cancel in COLLECT/IDLE SHALL credit the coin, then refund all (CHANGE, no vend).
REQ-024 coinType=00, or any coinValid in VEND/CHANGE, SHALL pulse coinReject the following cycle with credit unchanged.
REQ-025 credit SHALL never exceed PRICE_Q+3; 4-bit arithmetic SHALL not wrap.

Reset
REQ-026 rst SHALL immediately force IDLE, credit=0, guffin=0, changeReq=0, changeCoin=00, coinReject=0, busy=0, timeout counter 0.
REQ-027 Reset mid-VEND or mid-CHANGE SHALL discard credit without dispensing further coins.

Configuration
REQ-028 With GUFFIN_TIMEOUT_EN defined, TIMEOUT_CYC consecutive COLLECT cycles without coinValid SHALL force CHANGE (full refund); counter clears on any coin or state exit.
REQ-029 Without GUFFIN_TIMEOUT_EN, credit SHALL be held in COLLECT indefinitely and no counter logic SHALL exist.

Structure
REQ-030 Package guffin_pkg SHALL hold the state enum, coin-code enum (COIN_NONE, COIN_Q, COIN_H, COIN_D) and coin-value constants.
REQ-031 The timeout counter SHALL be sub-module guffin_timeout_ctr, instantiated only under GUFFIN_TIMEOUT_EN.

Verification
REQ-032 PRICE_Q=3: quarter, quarter, quarter -> guffin pulse one cycle after third coin, no changeReq, return to IDLE.
REQ-033 Half then dollar -> credit 6, guffin, remainder 3 -> changeCoin 10 then 01, each held until changeAck, then IDLE.
REQ-034 Quarter then cancel asserted with coinValid (half) same cycle -> no guffin, refund 10 then 01, credit 0.
REQ-035 Coin during CHANGE and coinType=00 in IDLE -> coinReject pulse, credit unchanged.
REQ-036 rst asserted mid-CHANGE with changeReq=1 -> outputs zero same cycle, IDLE after release.
REQ-037 GUFFIN_TIMEOUT_EN, TIMEOUT_CYC=10: one quarter then idle 10 cycles -> changeReq with changeCoin 01.

Source files
------------

// File: rtl/guffin_pkg.sv
// Shared types and constants for the guffin vending controller.
// Holds the FSM state enum, coin codes and coin values in quarters.
package guffin_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StVend    = 2'd2,
    StChange  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_Q    = 2'b01,
    COIN_H    = 2'b10,
    COIN_D    = 2'b11
  } coin_e;

  localparam logic [3:0] CoinValQ = 4'd1;
  localparam logic [3:0] CoinValH = 4'd2;
  localparam logic [3:0] CoinValD = 4'd4;

  function automatic logic [3:0] coin_value(coin_e c);
    case (c)
      COIN_Q:  return CoinValQ;
      COIN_H:  return CoinValH;
      COIN_D:  return CoinValD;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/guffin_vend_ctrl_if.sv
// Coin acceptor / dispenser bus of the guffin vending controller.
// master drives coins and handshakes; slave is the controller.
interface guffin_vend_ctrl_if;
  logic       coinValid;
  logic [1:0] coinType;
  logic       cancel;
  logic       changeAck;
  logic       guffin;
  logic       changeReq;
  logic [1:0] changeCoin;
  logic       coinReject;
  logic [3:0] credit;
  logic       busy;

  modport master (
    output coinValid, coinType, cancel, changeAck,
    input  guffin, changeReq, changeCoin, coinReject, credit, busy
  );

  modport slave (
    input  coinValid, coinType, cancel, changeAck,
    output guffin, changeReq, changeCoin, coinReject, credit, busy
  );
endinterface

// File: rtl/guffin_timeout_ctr.sv
// Idle-cycle counter for the collect-state auto-refund (GUFFIN_TIMEOUT_EN builds only).
// Counts consecutive enabled cycles; any disabled cycle clears it.
module guffin_timeout_ctr #(
  parameter int unsigned TimeoutCyc = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en_i,
  output logic expired_o
);
  localparam int unsigned CntW = (TimeoutCyc < 2) ? 1 : $clog2(TimeoutCyc);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Fires on the TimeoutCyc-th consecutive enabled cycle.
  assign expired_o = count_en_i && (cnt_q == CntW'(TimeoutCyc - 1));

  always_comb begin
    cnt_d = '0;
    if (count_en_i && !expired_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/guffin_vend_ctrl.sv
// Guffin vending controller: credits coins, vends at PRICE_Q, returns change/refunds.
// Define GUFFIN_TIMEOUT_EN to auto-refund after TIMEOUT_CYC idle collect cycles.
module guffin_vend_ctrl
  import guffin_pkg::*;
#(
  parameter int unsigned PRICE_Q     = 3,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic               clk,
  input logic               rst,
  guffin_vend_ctrl_if.slave bus
);
  localparam logic [3:0] Price     = 4'(PRICE_Q);
  localparam logic [4:0] MaxCredit = 5'(PRICE_Q + 3);

  state_e     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic       guffin_q, guffin_d;
  logic       change_req_q, change_req_d;
  coin_e      change_coin_q, change_coin_d;
  logic       coin_reject_q, coin_reject_d;
  logic       busy_q, busy_d;

  logic       coin_ok;
  logic [4:0] sum_wide;
  logic [3:0] coin_credit;
  logic       timeout_hit;

  assign coin_ok  = bus.coinValid && (coin_e'(bus.coinType) != COIN_NONE);
  assign sum_wide = {1'b0, credit_q} + {1'b0, coin_value(coin_e'(bus.coinType))};
  // Credit can only reach PRICE_Q+3 from below price; clamp keeps that explicit.
  assign coin_credit = (sum_wide > MaxCredit) ? MaxCredit[3:0] : sum_wide[3:0];

`ifdef GUFFIN_TIMEOUT_EN
  guffin_timeout_ctr #(
    .TimeoutCyc (TIMEOUT_CYC)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .count_en_i (state_q == StCollect && !bus.coinValid),
    .expired_o  (timeout_hit)
  );
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    unique case (state_q)
      StIdle, StCollect: begin
        if (coin_ok) credit_d = coin_credit;
        // A cancel with nothing credited (idle, no good coin) is ignored.
        if ((bus.cancel || timeout_hit) && credit_d != 4'd0) state_d = StChange;
        else if (credit_d >= Price)                          state_d = StVend;
        else if (credit_d != 4'd0)                           state_d = StCollect;
      end
      StVend: begin
        credit_d = credit_q - Price;
        state_d  = (credit_d != 4'd0) ? StChange : StIdle;
      end
      StChange: begin
        if (bus.changeAck) begin
          credit_d = credit_q - coin_value(change_coin_q);
          if (credit_d == 4'd0) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    guffin_d      = (state_d == StVend);
    change_req_d  = (state_d == StChange);
    change_coin_d = COIN_NONE;
    if (change_req_d) change_coin_d = (credit_d >= 4'd2) ? COIN_H : COIN_Q;
    coin_reject_d = bus.coinValid &&
                    ((coin_e'(bus.coinType) == COIN_NONE) || (state_q inside {StVend, StChange}));
    busy_d        = (state_d inside {StVend, StChange});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      credit_q      <= 4'd0;
      guffin_q      <= 1'b0;
      change_req_q  <= 1'b0;
      change_coin_q <= COIN_NONE;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      guffin_q      <= guffin_d;
      change_req_q  <= change_req_d;
      change_coin_q <= change_coin_d;
      coin_reject_q <= coin_reject_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.guffin     = guffin_q;
  assign bus.changeReq  = change_req_q;
  assign bus.changeCoin = change_coin_q;
  assign bus.coinReject = coin_reject_q;
  assign bus.credit     = credit_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_guffin_vend_ctrl.sv
// Directed self-checking bench for guffin_vend_ctrl with PRICE_Q=3, TIMEOUT_CYC=10.
module tb_guffin_vend_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  guffin_vend_ctrl_if bus ();

  guffin_vend_ctrl #(
    .PRICE_Q     (3),
    .TIMEOUT_CYC (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] t);
    bus.coinValid = 1'b1;
    bus.coinType  = t;
    tick();
    bus.coinValid = 1'b0;
    bus.coinType  = 2'b00;
  endtask

  task automatic ack();
    bus.changeAck = 1'b1;
    tick();
    bus.changeAck = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (bus.credit !== 4'd0) begin n_fail++; $display("FAIL rst_credit got %0d exp 0", bus.credit); end
    n_checks++; if ({bus.guffin, bus.changeReq, bus.changeCoin, bus.coinReject, bus.busy} !== 6'b0) begin
      n_fail++; $display("FAIL rst_outputs got %b exp 000000",
                         {bus.guffin, bus.changeReq, bus.changeCoin, bus.coinReject, bus.busy});
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_release_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_exact_price();
    coin(2'b01);
    n_checks++; if (bus.credit !== 4'd1) begin n_fail++; $display("FAIL exact_q1 got %0d exp 1", bus.credit); end
    coin(2'b01);
    n_checks++; if (bus.credit !== 4'd2 || bus.guffin !== 1'b0) begin
      n_fail++; $display("FAIL exact_q2 credit %0d guffin %b exp 2 0", bus.credit, bus.guffin); end
    coin(2'b01);
    n_checks++; if (bus.guffin !== 1'b1 || bus.busy !== 1'b1 || bus.credit !== 4'd3) begin
      n_fail++; $display("FAIL exact_vend guffin %b busy %b credit %0d exp 1 1 3", bus.guffin, bus.busy, bus.credit); end
    n_checks++; if (bus.changeReq !== 1'b0) begin n_fail++; $display("FAIL exact_vend_req got %b exp 0", bus.changeReq); end
    tick();
    n_checks++; if ({bus.guffin, bus.changeReq, bus.busy, bus.credit} !== 7'b0) begin
      n_fail++; $display("FAIL exact_idle got %b exp 0000000", {bus.guffin, bus.changeReq, bus.busy, bus.credit}); end
  endtask

  task automatic test_change();
    coin(2'b10);
    n_checks++; if (bus.credit !== 4'd2) begin n_fail++; $display("FAIL chg_half got %0d exp 2", bus.credit); end
    coin(2'b11);
    n_checks++; if (bus.credit !== 4'd6 || bus.guffin !== 1'b1) begin
      n_fail++; $display("FAIL chg_vend credit %0d guffin %b exp 6 1", bus.credit, bus.guffin); end
    tick();
    n_checks++; if (bus.guffin !== 1'b0 || bus.credit !== 4'd3 || bus.changeReq !== 1'b1 || bus.changeCoin !== 2'b10) begin
      n_fail++; $display("FAIL chg_first g %b cr %0d req %b coin %b exp 0 3 1 10",
                         bus.guffin, bus.credit, bus.changeReq, bus.changeCoin); end
    tick();
    n_checks++; if (bus.changeReq !== 1'b1 || bus.changeCoin !== 2'b10 || bus.credit !== 4'd3) begin
      n_fail++; $display("FAIL chg_hold req %b coin %b cr %0d exp 1 10 3", bus.changeReq, bus.changeCoin, bus.credit); end
    ack();
    n_checks++; if (bus.changeReq !== 1'b1 || bus.changeCoin !== 2'b01 || bus.credit !== 4'd1) begin
      n_fail++; $display("FAIL chg_second req %b coin %b cr %0d exp 1 01 1", bus.changeReq, bus.changeCoin, bus.credit); end
    tick();
    n_checks++; if (bus.changeCoin !== 2'b01 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL chg_hold2 coin %b busy %b exp 01 1", bus.changeCoin, bus.busy); end
    ack();
    n_checks++; if ({bus.changeReq, bus.changeCoin, bus.busy, bus.credit} !== 8'b0) begin
      n_fail++; $display("FAIL chg_done got %b exp 00000000", {bus.changeReq, bus.changeCoin, bus.busy, bus.credit}); end
  endtask

  task automatic test_cancel();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    n_checks++; if (bus.changeReq !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL cancel_idle req %b busy %b exp 0 0", bus.changeReq, bus.busy); end
    coin(2'b01);
    bus.changeAck = 1'b1;
    tick();
    bus.changeAck = 1'b0;
    n_checks++; if (bus.credit !== 4'd1 || bus.changeReq !== 1'b0) begin
      n_fail++; $display("FAIL ack_outside credit %0d req %b exp 1 0", bus.credit, bus.changeReq); end
    bus.cancel = 1'b1;
    coin(2'b10);
    bus.cancel = 1'b0;
    n_checks++; if (bus.guffin !== 1'b0 || bus.credit !== 4'd3 || bus.changeReq !== 1'b1 || bus.changeCoin !== 2'b10) begin
      n_fail++; $display("FAIL cancel_coin g %b cr %0d req %b coin %b exp 0 3 1 10",
                         bus.guffin, bus.credit, bus.changeReq, bus.changeCoin); end
    ack();
    n_checks++; if (bus.guffin !== 1'b0 || bus.credit !== 4'd1 || bus.changeCoin !== 2'b01) begin
      n_fail++; $display("FAIL cancel_q g %b cr %0d coin %b exp 0 1 01", bus.guffin, bus.credit, bus.changeCoin); end
    ack();
    n_checks++; if (bus.credit !== 4'd0 || bus.changeReq !== 1'b0) begin
      n_fail++; $display("FAIL cancel_done cr %0d req %b exp 0 0", bus.credit, bus.changeReq); end
  endtask

  task automatic test_reject();
    coin(2'b00);
    n_checks++; if (bus.coinReject !== 1'b1 || bus.credit !== 4'd0) begin
      n_fail++; $display("FAIL rej_invalid rej %b cr %0d exp 1 0", bus.coinReject, bus.credit); end
    tick();
    n_checks++; if (bus.coinReject !== 1'b0) begin n_fail++; $display("FAIL rej_pulse got %b exp 0", bus.coinReject); end
    coin(2'b10);
    coin(2'b11);
    tick();
    coin(2'b01);
    n_checks++; if (bus.coinReject !== 1'b1 || bus.credit !== 4'd3 || bus.changeCoin !== 2'b10) begin
      n_fail++; $display("FAIL rej_change rej %b cr %0d coin %b exp 1 3 10", bus.coinReject, bus.credit, bus.changeCoin); end
    tick();
    n_checks++; if (bus.coinReject !== 1'b0 || bus.credit !== 4'd3) begin
      n_fail++; $display("FAIL rej_after rej %b cr %0d exp 0 3", bus.coinReject, bus.credit); end
    ack();
    ack();
  endtask

  task automatic test_back_to_back();
    coin(2'b11);
    n_checks++; if (bus.guffin !== 1'b1 || bus.credit !== 4'd4) begin
      n_fail++; $display("FAIL b2b_vend g %b cr %0d exp 1 4", bus.guffin, bus.credit); end
    coin(2'b01);
    n_checks++; if (bus.coinReject !== 1'b1 || bus.credit !== 4'd1 || bus.changeCoin !== 2'b01) begin
      n_fail++; $display("FAIL b2b_rej rej %b cr %0d coin %b exp 1 1 01", bus.coinReject, bus.credit, bus.changeCoin); end
    ack();
    coin(2'b11);
    n_checks++; if (bus.guffin !== 1'b1 || bus.credit !== 4'd4) begin
      n_fail++; $display("FAIL b2b_vend2 g %b cr %0d exp 1 4", bus.guffin, bus.credit); end
    tick();
    ack();
    n_checks++; if (bus.busy !== 1'b0 || bus.credit !== 4'd0) begin
      n_fail++; $display("FAIL b2b_done busy %b cr %0d exp 0 0", bus.busy, bus.credit); end
  endtask

  task automatic test_reset_mid_change();
    coin(2'b10);
    coin(2'b11);
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if ({bus.changeReq, bus.changeCoin, bus.busy, bus.credit, bus.guffin} !== 9'b0) begin
      n_fail++; $display("FAIL rst_mid got %b exp 000000000",
                         {bus.changeReq, bus.changeCoin, bus.busy, bus.credit, bus.guffin}); end
    tick();
    rst = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.changeReq !== 1'b0 || bus.credit !== 4'd0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_after req %b cr %0d busy %b exp 0 0 0", bus.changeReq, bus.credit, bus.busy); end
  endtask

  task automatic test_timeout();
    coin(2'b01);
    repeat (9) tick();
    n_checks++; if (bus.changeReq !== 1'b0 || bus.credit !== 4'd1) begin
      n_fail++; $display("FAIL to_early req %b cr %0d exp 0 1", bus.changeReq, bus.credit); end
    tick();
`ifdef GUFFIN_TIMEOUT_EN
    n_checks++; if (bus.changeReq !== 1'b1 || bus.changeCoin !== 2'b01) begin
      n_fail++; $display("FAIL to_fire req %b coin %b exp 1 01", bus.changeReq, bus.changeCoin); end
    ack();
`else
    repeat (10) tick();
    n_checks++; if (bus.changeReq !== 1'b0 || bus.credit !== 4'd1) begin
      n_fail++; $display("FAIL to_hold req %b cr %0d exp 0 1", bus.changeReq, bus.credit); end
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    ack();
`endif
    n_checks++; if (bus.credit !== 4'd0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL to_done cr %0d busy %b exp 0 0", bus.credit, bus.busy); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.coinValid = 1'b0;
    bus.coinType  = 2'b00;
    bus.cancel    = 1'b0;
    bus.changeAck = 1'b0;
    #3;
    test_reset();
    test_exact_price();
    test_change();
    test_cancel();
    test_reject();
    test_back_to_back();
    test_reset_mid_change();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
